// File: rtl/fft_band_beat.sv
// fft_band_beat: per-frame band energy accumulation and beat detection.
//
// Consumes the FFT magnitude unload stream (mag_valid, xk_index, Magnitude).
// Only the lower half of the spectrum is used. It is split into NUM_BANDS
// equal bands. At end of frame each band energy is compared with a per-band
// exponential running average, and one result per band is streamed out.
//
// Result stream handshake: out_valid is a one-cycle strobe per band with no
// back-pressure. out_band, out_energy and out_beat are meaningful only while
// out_valid=1. Bands come out in order 0..NUM_BANDS-1 on consecutive cycles,
// and frame_done pulses on the cycle after the last band.
//
// Optional feature: define FFT_BAND_BEAT_HOLDOFF_EN to add a per-band
// holdoff counter. It suppresses a band's beats for HOLDOFF_FRAMES frames
// after that band fires.
//
// Assumes NUM_BANDS >= 2 and a power of two. The last lower-half bin then
// falls in the top band, so band 0 is already final when it is reported.

module fft_band_beat #(
    parameter int NFFT_LOG2      = 10,
    parameter int NUM_BANDS      = 8,
    parameter int MAG_W          = 32,
    parameter int ACC_W          = 40,
    parameter int AVG_SHIFT      = 3,
    parameter int MIN_ENERGY     = 256,
    parameter int HOLDOFF_FRAMES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mag_valid,
    input  logic [NFFT_LOG2-1:0]         xk_index,
    input  logic [MAG_W-1:0]             Magnitude,
    output logic                         out_valid,
    output logic [$clog2(NUM_BANDS)-1:0] out_band,
    output logic [ACC_W-1:0]             out_energy,
    output logic                         out_beat,
    output logic                         frame_done,
    output logic                         beat_any,
    output logic                         frame_err,
    output logic [1:0]                   state_dbg
);

    localparam int BAND_W = $clog2(NUM_BANDS);
    localparam logic [NFFT_LOG2-1:0] LAST_BIN  = NFFT_LOG2'((2 ** (NFFT_LOG2 - 1)) - 1);
    localparam logic [BAND_W-1:0]    LAST_BAND = BAND_W'(NUM_BANDS - 1);
    localparam logic [ACC_W-1:0]     MIN_E     = ACC_W'(MIN_ENERGY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               state;
    logic [ACC_W-1:0]     acc [NUM_BANDS];
    logic [ACC_W-1:0]     avg [NUM_BANDS];
    logic                 warm;
    logic [BAND_W-1:0]    band_cnt;
    logic [NUM_BANDS-1:0] beat_vec;

    assign state_dbg = state;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

    // Input bin decode.
    logic              bin_lower;
    logic              bin_zero;
    logic [BAND_W-1:0] bin_band;
    logic [ACC_W-1:0]  mag_ext;

    assign bin_lower = ~xk_index[NFFT_LOG2-1];
    assign bin_zero  = (xk_index == '0);
    assign bin_band  = xk_index[NFFT_LOG2-2 -: BAND_W];
    assign mag_ext   = ACC_W'(Magnitude);

    // A band result is loaded into the output registers on the edge before
    // it is presented. The first band loads as the last bin is accepted, and
    // each later band loads while the previous one is on the outputs.
    logic last_bin_hit;
    logic emit;

    assign last_bin_hit = (state == ACCUM) && mag_valid && !bin_zero && (xk_index == LAST_BIN);
    assign emit         = last_bin_hit || ((state == UPDATE) && (band_cnt != LAST_BAND));

    logic              hold_clear;
    logic [BAND_W-1:0] eval_band;
    logic [ACC_W-1:0]  eval_energy;
    logic [ACC_W-1:0]  eval_avg;
    logic [ACC_W-1:0]  eval_thr;
    logic [ACC_W-1:0]  eval_avg_next;
    logic              eval_beat;

`ifdef FFT_BAND_BEAT_HOLDOFF_EN
    localparam int HOLD_W = $clog2(HOLDOFF_FRAMES + 1);
    logic [HOLD_W-1:0] hold_cnt [NUM_BANDS];
    assign hold_clear = (hold_cnt[eval_band] == '0);
`else
    assign hold_clear = 1'b1;
`endif

    // Threshold, beat decision and average update for the band being loaded.
    always_comb begin
        eval_band     = (state == UPDATE) ? band_cnt + BAND_W'(1) : '0;
        eval_energy   = acc[eval_band];
        eval_avg      = avg[eval_band];
        eval_thr      = sat_add(eval_avg, eval_avg >> 1);
        eval_avg_next = warm ? (eval_avg - (eval_avg >> AVG_SHIFT) + (eval_energy >> AVG_SHIFT))
                             : eval_energy;
        eval_beat     = warm && (eval_energy > eval_thr) && (eval_energy >= MIN_E) && hold_clear;
    end

    // Frame FSM: accumulate bins, stream band results, then publish frame status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            band_cnt   <= '0;
            warm       <= 1'b0;
            beat_vec   <= '0;
            out_valid  <= 1'b0;
            out_band   <= '0;
            out_energy <= '0;
            out_beat   <= 1'b0;
            frame_done <= 1'b0;
            beat_any   <= 1'b0;
            frame_err  <= 1'b0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                acc[b] <= '0;
                avg[b] <= '0;
`ifdef FFT_BAND_BEAT_HOLDOFF_EN
                hold_cnt[b] <= '0;
`endif
            end
        end else begin
            out_valid  <= 1'b0;
            out_beat   <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (mag_valid && bin_zero) begin
                        for (int b = 0; b < NUM_BANDS; b++) acc[b] <= '0;
                        acc[0] <= mag_ext;
                        state  <= ACCUM;
                    end
                end

                ACCUM: begin
                    if (mag_valid && bin_zero) begin
                        // Bin 0 in mid-frame: the source restarted, so drop the partial frame.
                        frame_err <= 1'b1;
                        for (int b = 0; b < NUM_BANDS; b++) acc[b] <= '0;
                        acc[0] <= mag_ext;
                    end else if (mag_valid && bin_lower) begin
                        acc[bin_band] <= sat_add(acc[bin_band], mag_ext);
                        if (last_bin_hit) begin
                            state    <= UPDATE;
                            band_cnt <= '0;
                        end
                    end
                end

                UPDATE: begin
                    // A new frame cannot start while results are streaming out.
                    if (mag_valid && bin_zero) frame_err <= 1'b1;
                    if (band_cnt == LAST_BAND) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                        beat_any   <= |beat_vec;
                        warm       <= 1'b1;
`ifdef FFT_BAND_BEAT_HOLDOFF_EN
                        for (int b = 0; b < NUM_BANDS; b++) begin
                            if (beat_vec[b]) hold_cnt[b] <= HOLD_W'(HOLDOFF_FRAMES);
                            else if (hold_cnt[b] != '0) hold_cnt[b] <= hold_cnt[b] - HOLD_W'(1);
                        end
`endif
                    end else begin
                        band_cnt <= band_cnt + BAND_W'(1);
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase

            if (emit) begin
                out_valid           <= 1'b1;
                out_band            <= eval_band;
                out_energy          <= eval_energy;
                out_beat            <= eval_beat;
                avg[eval_band]      <= eval_avg_next;
                beat_vec[eval_band] <= eval_beat;
            end
        end
    end

endmodule
